dca_matrix_lsu_wbeat_gen: RTL and testbench
===========================================

Name: dca_matrix_lsu_wbeat_gen

Overview:
- Downstream neighbour of the matrix LSU write-row merger.
- Accepts one merged memory row per handshake: row data, byte strobes, and which segments to send.
- Slices the row into AXI-data-width beats and drives the AXI W channel (wvalid/wready/wdata/wstrb/wlast).
- Tracks burst beat count and flags protocol violations.

Parameters:
- BW_ROW_BUFFER, 256, width of merged memory row in bits; must be a multiple of BW_AXI_DATA.
- BW_AXI_DATA, 32, AXI W data width in bits.
- NUM_SEG, BW_ROW_BUFFER/BW_AXI_DATA (derived localparam), beats per full row; power of two, ≥2.
- BW_SEG, log2(NUM_SEG) (derived localparam), segment index width.

Ports:
- clk  input  1  clock.
- rstnn  input  1  reset; synchronous and active-low, sampled on the rising edge of clk.
- row_valid  input  1  merged row available.
- row_ready  output  1  row accepted when row_valid & row_ready.
- row_data  input  BW_ROW_BUFFER  merged row.
- row_wstrb  input  BW_ROW_BUFFER/8  byte strobes for row_data.
- row_start_seg  input  BW_SEG  first segment to send.
- row_num_seg_m1  input  BW_SEG  segments to send minus 1.
- row_burst_last  input  1  final beat of this row ends the AXI burst.
- wvalid  output  1  AXI W valid.
- wready  input  1  AXI W ready.
- wdata  output  BW_AXI_DATA  beat data.
- wstrb  output  BW_AXI_DATA/8  beat strobes.
- wlast  output  1  AXI W last.
- busy  output  1  row held or burst open.
- err_seg_range  output  1  sticky: start+num_m1 exceeded NUM_SEG-1.
- err_burst_len  output  1  sticky: 256 beats sent without wlast.

Behaviour:
- Reset (rstnn==0 at a clk edge): state=IDLE, wvalid=0, wlast=0, wdata=0, wstrb=0, busy=0, both error flags=0, burst counter=0, latched row cleared. Reset mid-burst discards the held row without completing it.
- FSM states: IDLE and SEND.
- row_ready = (state==IDLE) | (state==SEND & wready & cur_seg==end_seg). This allows back-to-back rows with no bubble.
- Row accept: latch row_data, row_wstrb and row_burst_last; set cur_seg=row_start_seg; go to SEND.
  - end_seg = row_start_seg + row_num_seg_m1, computed in BW_SEG+1 bits.
  - If the sum > NUM_SEG-1: clamp end_seg to NUM_SEG-1 and set err_seg_range.
- SEND outputs:
  - wvalid=1.
  - wdata = latched row bits [cur_seg*BW_AXI_DATA +: BW_AXI_DATA].
  - wstrb = corresponding strobe slice.
  - wlast = (cur_seg==end_seg) & latched burst_last.
  - All W outputs are driven from registers/muxes of registered state; no combinational path from row_* to w*.
- Beat handshake (wvalid & wready):
  - If cur_seg != end_seg: cur_seg+1.
  - Else if row_valid: accept the new row in the same cycle and stay in SEND.
  - Else: go to IDLE, wvalid=0.
- AXI stability: wdata/wstrb/wlast hold while wvalid & ~wready.
- Beats with all-zero strobes are still sent; they are never skipped.
- Burst counter (9 bits): increments on each beat handshake; cleared on a handshake with wlast=1. A beat handshake at count 255 without wlast sets err_burst_len; the counter saturates at 256.
- busy = (state==SEND) | (burst counter != 0).
- Latency: a row accepted at edge N presents its first beat (wvalid=1) from cycle N+1. A row of k segments with wready held high takes exactly k cycles.

Test Plan:
- Defaults. Row with data word j = 0x1000_0000+j, wstrb all-ones, start 0, num_m1 7, burst_last 1; wready=1 → 8 consecutive beats with wdata 0x10000000..0x10000007, wstrb 0xF, wlast only on beat 8, row_ready low during beats 1-7.
- Partial row: start 5, num_m1 2, burst_last 0 → 3 beats carrying segments 5,6,7; wlast=0 throughout; busy stays 1 afterwards (burst open).
- Backpressure: wready toggles 1,0,0,1,... → wdata/wstrb/wlast remain stable while stalled; beat order unchanged; total beats equal the segment count.
- Back-to-back: second row valid during the final beat of the first (num_m1 1 each) → 4 beats over 4 cycles with no gap; second row accepted on the first row's last handshake.
- Range error: start 6, num_m1 3 → only segments 6,7 sent; err_seg_range=1 and stays 1 until reset.
- Burst overflow: 32 full rows with burst_last=0 → err_burst_len rises on the 256th beat handshake. Then assert rstnn=0 mid-row → next edge gives wvalid=0, flags=0, state IDLE, row_ready=1.

Source files
------------

// File: rtl/dca_matrix_lsu_wbeat_gen_if.sv
// Matrix LSU W-beat generator bus: merged-row input side plus AXI W side.
// slave = beat generator, master = row producer / W consumer.
`timescale 1ns/1ps
interface dca_matrix_lsu_wbeat_gen_if #(
  parameter int BW_ROW_BUFFER = 256,
  parameter int BW_AXI_DATA   = 32
);
  localparam int NUM_SEG = BW_ROW_BUFFER / BW_AXI_DATA;
  localparam int BW_SEG  = $clog2(NUM_SEG);

  logic                       row_valid;
  logic                       row_ready;
  logic [BW_ROW_BUFFER-1:0]   row_data;
  logic [BW_ROW_BUFFER/8-1:0] row_wstrb;
  logic [BW_SEG-1:0]          row_start_seg;
  logic [BW_SEG-1:0]          row_num_seg_m1;
  logic                       row_burst_last;

  logic                       wvalid;
  logic                       wready;
  logic [BW_AXI_DATA-1:0]     wdata;
  logic [BW_AXI_DATA/8-1:0]   wstrb;
  logic                       wlast;

  modport master (
    output row_valid, row_data, row_wstrb,
    output row_start_seg, row_num_seg_m1,
    output row_burst_last,
    input  row_ready,
    input  wvalid, wdata, wstrb, wlast,
    output wready
  );

  modport slave (
    input  row_valid, row_data, row_wstrb,
    input  row_start_seg, row_num_seg_m1,
    input  row_burst_last,
    output row_ready,
    output wvalid, wdata, wstrb, wlast,
    input  wready
  );
endinterface

// File: rtl/dca_matrix_lsu_wbeat_gen.sv
// Slices merged LSU rows into AXI W beats, tracks burst
// length and flags segment-range and burst-length errors.
`timescale 1ns/1ps
module dca_matrix_lsu_wbeat_gen #(
  parameter int BW_ROW_BUFFER = 256,
  parameter int BW_AXI_DATA   = 32
) (
  input  logic clk,
  input  logic rstnn,
  dca_matrix_lsu_wbeat_gen_if.slave bus,
  output logic busy,
  output logic err_seg_range,
  output logic err_burst_len
);
  localparam int NUM_SEG = BW_ROW_BUFFER / BW_AXI_DATA;
  localparam int BW_SEG  = $clog2(NUM_SEG);
  localparam int BW_RSTB = BW_ROW_BUFFER / 8;
  localparam int BW_WSTB = BW_AXI_DATA / 8;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   r_state;
  state_t                   w_state_n;
  logic [BW_ROW_BUFFER-1:0] r_data;
  logic [BW_RSTB-1:0]       r_strb;
  logic                     r_burst_last;
  logic [BW_SEG-1:0]        r_cur;
  logic [BW_SEG-1:0]        r_end;
  logic [8:0]               r_cnt;
  logic                     r_err_seg;
  logic                     r_err_len;

  logic              w_send;
  logic              w_at_end;
  logic              w_hs;
  logic              w_acc;
  logic              w_ovf;
  logic [BW_SEG:0]   w_sum;
  logic [BW_SEG-1:0] w_end;

  assign w_send   = (r_state == SEND);
  assign w_at_end = (r_cur == r_end);
  assign w_hs     = w_send & bus.wready;
  assign w_acc    = bus.row_valid & bus.row_ready;

  // NUM_SEG is a power of two, so the carry bit is the overflow
  assign w_sum = {1'b0, bus.row_start_seg}
               + {1'b0, bus.row_num_seg_m1};
  assign w_ovf = w_sum[BW_SEG];
  assign w_end = w_ovf ? '1 : w_sum[BW_SEG-1:0];

  assign bus.row_ready = ~w_send | (w_hs & w_at_end);

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE: if (bus.row_valid) w_state_n = SEND;
      SEND: if (w_hs & w_at_end & ~bus.row_valid)
              w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstnn) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      r_data       <= '0;
      r_strb       <= '0;
      r_burst_last <= 1'b0;
      r_cur        <= '0;
      r_end        <= '0;
      r_cnt        <= '0;
      r_err_seg    <= 1'b0;
      r_err_len    <= 1'b0;
    end else begin
      if (w_acc) begin
        r_data       <= bus.row_data;
        r_strb       <= bus.row_wstrb;
        r_burst_last <= bus.row_burst_last;
        r_cur        <= bus.row_start_seg;
        r_end        <= w_end;
      end else if (w_hs & ~w_at_end) begin
        r_cur <= r_cur + 1'b1;
      end
      if (w_acc & w_ovf) r_err_seg <= 1'b1;
      // counter parks at 256 once the length limit is blown
      if (w_hs) begin
        if (bus.wlast) begin
          r_cnt <= '0;
        end else if (r_cnt == 9'd255) begin
          r_cnt     <= 9'd256;
          r_err_len <= 1'b1;
        end else if (r_cnt != 9'd256) begin
          r_cnt <= r_cnt + 9'd1;
        end
      end
    end
  end

  assign bus.wvalid = w_send;
  assign bus.wdata  = w_send ?
    r_data[r_cur*BW_AXI_DATA +: BW_AXI_DATA] : '0;
  assign bus.wstrb  = w_send ?
    r_strb[r_cur*BW_WSTB +: BW_WSTB] : '0;
  assign bus.wlast  = w_send & w_at_end & r_burst_last;

  assign busy          = w_send | (r_cnt != 9'd0);
  assign err_seg_range = r_err_seg;
  assign err_burst_len = r_err_len;
endmodule

// File: tb/tb_dca_matrix_lsu_wbeat_gen.sv
// Scoreboard bench for the LSU W-beat generator.
// Expected beats are queued on row accept, popped on W handshakes.
`timescale 1ns/1ps
module tb_dca_matrix_lsu_wbeat_gen;
  localparam int BR = 256;
  localparam int BA = 32;

  logic clk = 1'b0;
  logic rstnn = 1'b0;
  logic busy, err_seg_range, err_burst_len;

  always #5 clk = ~clk;

  dca_matrix_lsu_wbeat_gen_if #(
    .BW_ROW_BUFFER(BR), .BW_AXI_DATA(BA)
  ) bus ();

  dca_matrix_lsu_wbeat_gen #(
    .BW_ROW_BUFFER(BR), .BW_AXI_DATA(BA)
  ) u_dut (
    .clk          (clk),
    .rstnn        (rstnn),
    .bus          (bus),
    .busy         (busy),
    .err_seg_range(err_seg_range),
    .err_burst_len(err_burst_len)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  stb;
    logic        lst;
    logic        eor;
  } beat_t;

  beat_t sbq[$];
  beat_t e;
  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int m_cnt   = 0;
  logic m_err = 1'b0;
  int wmode   = 0;
  int h0;

  logic        stall_q = 1'b0;
  logic [31:0] hd;
  logic [3:0]  hsb;
  logic        hl;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BR-1:0] mk_row(input logic [31:0] b);
    logic [BR-1:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = b + j;
    return r;
  endfunction

  // W consumer: always ready, or a 1,0,0 ready pattern
  initial begin
    int ph;
    ph = 0;
    bus.wready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (wmode == 1) begin
        bus.wready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        bus.wready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rstnn) begin
      sbq.delete();
      stall_q = 1'b0;
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      chk("err_burst_len", err_burst_len, m_err);
      if (bus.wvalid) begin
        if (stall_q) begin
          chk("hold_wdata", bus.wdata, hd);
          chk("hold_wstrb", bus.wstrb, hsb);
          chk("hold_wlast", bus.wlast, hl);
        end
        chk("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq[0];
          chk("wdata", bus.wdata, e.dat);
          chk("wstrb", bus.wstrb, e.stb);
          chk("wlast", bus.wlast, e.lst);
          chk("row_ready", bus.row_ready, bus.wready & e.eor);
          if (bus.wready) begin
            void'(sbq.pop_front());
            hs_cnt++;
            if (e.lst) m_cnt = 0;
            else if (m_cnt == 255) begin
              m_cnt = 256;
              m_err = 1'b1;
            end else if (m_cnt < 256) m_cnt++;
          end
        end
        stall_q = ~bus.wready;
        hd  = bus.wdata;
        hsb = bus.wstrb;
        hl  = bus.wlast;
      end else begin
        stall_q = 1'b0;
      end
    end
  end

  task automatic send_row(input logic [BR-1:0] d,
                          input logic [31:0] s,
                          input int st, input int nm,
                          input logic bl);
    bit ok;
    int t;
    int en;
    logic [2:0] st3, nm3;
    st3 = st[2:0];
    nm3 = nm[2:0];
    bus.row_valid      = 1'b1;
    bus.row_data       = d;
    bus.row_wstrb      = s;
    bus.row_start_seg  = st3;
    bus.row_num_seg_m1 = nm3;
    bus.row_burst_last = bl;
    ok = 1'b0;
    t = 0;
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = bus.row_ready;
      @(posedge clk);
      #1;
      t++;
    end
    chk("row_accept", ok, 1);
    en = st + nm;
    if (en > 7) en = 7;
    for (int k = st; k <= en; k++)
      sbq.push_back('{dat: d[k*32 +: 32], stb: s[k*4 +: 4],
                      lst: (k == en) && bl, eor: (k == en)});
  endtask

  task automatic idle();
    bus.row_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((sbq.size() != 0 || bus.wvalid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(tag, sbq.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wvalid"}, bus.wvalid, 0);
    chk({tag, "_wlast"}, bus.wlast, 0);
    chk({tag, "_wdata"}, bus.wdata, 0);
    chk({tag, "_wstrb"}, bus.wstrb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_errseg"}, err_seg_range, 0);
    chk({tag, "_errlen"}, err_burst_len, 0);
    chk({tag, "_rready"}, bus.row_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.row_valid      = 1'b0;
    bus.row_data       = '0;
    bus.row_wstrb      = '0;
    bus.row_start_seg  = '0;
    bus.row_num_seg_m1 = '0;
    bus.row_burst_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk);
    #1;
    rstnn = 1'b1;

    // full row, no backpressure: 8 beats in 8 cycles
    send_row(mk_row(32'h1000_0000), '1, 0, 7, 1'b1);
    h0 = hs_cnt;
    idle();
    repeat (8) @(negedge clk);
    #1;
    chk("t1_beats", hs_cnt - h0, 8);
    drain("t1_drain");
    chk("t1_busy", busy, 0);

    // partial row, burst left open, one all-zero strobe beat
    send_row(mk_row(32'h2000_0000), 32'hA0F0_3C5A, 5, 2, 1'b0);
    idle();
    drain("t2_drain");
    chk("t2_busy", busy, 1);

    // backpressure
    wmode = 1;
    h0 = hs_cnt;
    send_row(mk_row(32'h3000_0000), 32'h1234_5678, 1, 5, 1'b1);
    idle();
    drain("t3_drain");
    wmode = 0;
    chk("t3_beats", hs_cnt - h0, 6);
    chk("t3_busy", busy, 0);

    // back-to-back rows with no bubble
    send_row(mk_row(32'h4000_0000), '1, 2, 1, 1'b0);
    h0 = hs_cnt;
    send_row(mk_row(32'h5000_0000), 32'hFFF0_0FFF, 6, 1, 1'b1);
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("t4_beats", hs_cnt - h0, 4);
    drain("t4_drain");

    // segment range overflow, sticky
    chk("t5_errseg_pre", err_seg_range, 0);
    send_row(mk_row(32'h6000_0000), '1, 6, 3, 1'b1);
    idle();
    drain("t5_drain");
    chk("t5_errseg", err_seg_range, 1);
    send_row(mk_row(32'h7000_0000), '1, 0, 0, 1'b1);
    idle();
    drain("t5b_drain");
    chk("t5_errseg_sticky", err_seg_range, 1);

    // 256 beats without wlast
    for (int r = 0; r < 32; r++)
      send_row(mk_row(32'h8000_0000 + (r << 8)), '1, 0, 7, 1'b0);
    idle();
    drain("t6_drain");
    chk("t6_errlen", err_burst_len, 1);
    chk("t6_busy", busy, 1);

    // reset in the middle of a row
    send_row(mk_row(32'h9000_0000), '1, 0, 7, 1'b1);
    idle();
    repeat (2) @(posedge clk);
    #1;
    rstnn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset("midrst");
    @(posedge clk);
    #1;
    rstnn = 1'b1;

    send_row(mk_row(32'hA000_0000), '1, 3, 0, 1'b1);
    idle();
    drain("t7_drain");
    chk("t7_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
